// File: rtl/ebus_diag_reader.sv
// ----------------------------------------------------------------------------
// ebus_diag_reader
//
// Requester end of the EDP diagnostic-read path over EBUS. A front-end request
// selects one of the AR/BR/MQ/FM/BRX/ARX/ADX/AD registers (or a scan from that
// select up to AD). For every word the block raises diag_read_12x with the
// register select on diag_sel and waits for EDP to drive EBUS. It then samples
// ebus_data and returns the word over a valid/ready response channel.
//
// Ports
//   clk            EBOX clock (CLK.EDP domain), all state changes on posedge
//   reset_n        synchronous active-low reset
//   req_valid/req_ready/req_sel/req_scan   request channel
//   diag_read_12x  CTL.DIAG_READ_FUNC_12x
//   diag_sel       CTL.DIAG[4:6]
//   ebus_driving   EDP.EBUSdriver.driving
//   ebus_data      EBUS.data[0:35]
//   rsp_valid/rsp_ready/rsp_data/rsp_sel/rsp_last/rsp_err/rsp_par
//                  response channel; rsp_data is 0 and rsp_err is 1 on timeout
//
// Parameters
//   SETTLE_CYCLES  cycles of ebus_driving=1 in SETTLE before sampling (>= 1)
//   TIMEOUT        cycles in ISSUE/SETTLE without capture before an error word
//                  is returned (> SETTLE_CYCLES)
//
// Build option
//   EBUS_DIAG_PARITY_EN : when defined, rsp_par carries the odd parity of
//                         rsp_data and is registered with it. When undefined,
//                         rsp_par is tied to 0 and no parity logic exists.
// ----------------------------------------------------------------------------
module ebus_diag_reader #(
  parameter int SETTLE_CYCLES = 2,
  parameter int TIMEOUT       = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [0:2]  req_sel,
  input  logic        req_scan,
  output logic        diag_read_12x,
  output logic [0:2]  diag_sel,
  input  logic        ebus_driving,
  input  logic [0:35] ebus_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [0:35] rsp_data,
  output logic [0:2]  rsp_sel,
  output logic        rsp_last,
  output logic        rsp_err,
  output logic        rsp_par
);

  localparam int SW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
  localparam logic [0:2]    SEL_AD      = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // State and working registers
  state_t         r_state;
  logic [0:2]     r_cur_sel;
  logic           r_scan;
  logic [SW-1:0]  r_settle_cnt;
  logic [TW-1:0]  r_to_cnt;

  // Registered outputs
  logic           r_req_ready;
  logic           r_diag_read_12x;
  logic [0:2]     r_diag_sel;
  logic           r_rsp_valid;
  logic [0:35]    r_rsp_data;
  logic           r_rsp_last;
  logic           r_rsp_err;

  // Next-state values
  state_t         w_state_nxt;
  logic [0:2]     w_cur_sel_nxt;
  logic           w_scan_nxt;
  logic [SW-1:0]  w_settle_nxt;
  logic [TW-1:0]  w_to_nxt;
  logic [0:35]    w_data_nxt;
  logic           w_err_nxt;
  logic           w_last_nxt;
  logic           w_capture;
  logic           w_timeout;
  logic           w_load;

  // Next-state logic: request accept, settle/timeout counting, word capture and scan stepping
  always_comb begin
    w_state_nxt   = r_state;
    w_cur_sel_nxt = r_cur_sel;
    w_scan_nxt    = r_scan;
    w_settle_nxt  = r_settle_cnt;
    w_to_nxt      = r_to_cnt;
    w_data_nxt    = r_rsp_data;
    w_err_nxt     = r_rsp_err;
    w_last_nxt    = r_rsp_last;
    w_capture     = 1'b0;
    w_timeout     = 1'b0;
    w_load        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_cur_sel_nxt = req_sel;
          w_scan_nxt    = req_scan;
          w_settle_nxt  = '0;
          w_to_nxt      = '0;
          w_state_nxt   = ST_ISSUE;
        end else begin
          w_state_nxt   = ST_IDLE;
        end
      end

      ST_ISSUE, ST_SETTLE: begin
        w_to_nxt = r_to_cnt + TW'(1'b1);
        // ISSUE gives EDP one cycle to see the read function before driving
        // counts; settle_cnt only advances in SETTLE and holds when driving drops.
        if ((r_state == ST_SETTLE) && ebus_driving) begin
          w_settle_nxt = r_settle_cnt + SW'(1'b1);
          w_capture    = (r_settle_cnt == SETTLE_LAST);
        end else begin
          w_settle_nxt = r_settle_cnt;
          w_capture    = 1'b0;
        end
        w_timeout = (r_to_cnt == TO_LAST);

        // Capture has priority over a timeout on the same edge.
        if (w_capture) begin
          w_data_nxt  = ebus_data;
          w_err_nxt   = 1'b0;
          w_last_nxt  = ~r_scan | (r_cur_sel == SEL_AD);
          w_load      = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_timeout) begin
          w_data_nxt  = 36'd0;
          w_err_nxt   = 1'b1;
          w_last_nxt  = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_SETTLE;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          if (r_rsp_last) begin
            w_state_nxt   = ST_IDLE;
          end else begin
            // rsp_last is forced at select 7, so this increment never wraps.
            w_cur_sel_nxt = r_cur_sel + 3'd1;
            w_settle_nxt  = '0;
            w_to_nxt      = '0;
            w_state_nxt   = ST_ISSUE;
          end
        end else begin
          w_state_nxt = ST_RESP;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counters and output registers; outputs are decoded from the next state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state         <= ST_IDLE;
      r_cur_sel       <= 3'd0;
      r_scan          <= 1'b0;
      r_settle_cnt    <= '0;
      r_to_cnt        <= '0;
      r_req_ready     <= 1'b1;
      r_diag_read_12x <= 1'b0;
      r_diag_sel      <= 3'd0;
      r_rsp_valid     <= 1'b0;
      r_rsp_data      <= 36'd0;
      r_rsp_last      <= 1'b0;
      r_rsp_err       <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_cur_sel       <= w_cur_sel_nxt;
      r_scan          <= w_scan_nxt;
      r_settle_cnt    <= w_settle_nxt;
      r_to_cnt        <= w_to_nxt;
      r_req_ready     <= (w_state_nxt == ST_IDLE);
      r_diag_read_12x <= (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_SETTLE);
      r_diag_sel      <= ((w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_SETTLE)) ?
                         w_cur_sel_nxt : 3'd0;
      r_rsp_valid     <= (w_state_nxt == ST_RESP);
      r_rsp_data      <= w_data_nxt;
      r_rsp_last      <= w_last_nxt;
      r_rsp_err       <= w_err_nxt;
    end
  end

`ifdef EBUS_DIAG_PARITY_EN
  logic r_rsp_par;

  // Odd parity over a 36-bit word: 1 when the word has an even number of ones
  function automatic logic odd_par(input logic [0:35] d);
    return ~^d;
  endfunction

  // Parity register, loaded on the same edge as the captured or error word
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rsp_par <= 1'b0;
    end else if (w_load) begin
      r_rsp_par <= odd_par(w_data_nxt);
    end else begin
      r_rsp_par <= r_rsp_par;
    end
  end

  assign rsp_par = r_rsp_par;
`else
  assign rsp_par = 1'b0;
`endif

  assign req_ready     = r_req_ready;
  assign diag_read_12x = r_diag_read_12x;
  assign diag_sel      = r_diag_sel;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_data      = r_rsp_data;
  assign rsp_sel       = r_cur_sel;
  assign rsp_last      = r_rsp_last;
  assign rsp_err       = r_rsp_err;

endmodule

// File: tb/tb_ebus_diag_reader.sv
// ----------------------------------------------------------------------------
// Self-checking bench for ebus_diag_reader. A small EDP model drives EBUS
// from a per-select word table whenever it is commanded and enabled. The
// expected response sequence follows from the request alone: one word for a
// single read, 8-sel words for a scan, one error word on a silent bus.
// ----------------------------------------------------------------------------
module tb_ebus_diag_reader;

  localparam int SETTLE = 2;
  localparam int TMO    = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [0:2]  req_sel;
  logic        req_scan;
  logic        diag_read_12x;
  logic [0:2]  diag_sel;
  logic        ebus_driving;
  logic [0:35] ebus_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:35] rsp_data;
  logic [0:2]  rsp_sel;
  logic        rsp_last;
  logic        rsp_err;
  logic        rsp_par;

  logic        drv_en;
  logic [0:35] tbl [8];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // EDP model: drives the addressed register whenever the read function is up
  assign ebus_driving = drv_en & diag_read_12x;
  assign ebus_data    = ebus_driving ? tbl[diag_sel] : 36'd0;

  ebus_diag_reader #(.SETTLE_CYCLES(SETTLE), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel), .req_scan(req_scan),
    .diag_read_12x(diag_read_12x), .diag_sel(diag_sel),
    .ebus_driving(ebus_driving), .ebus_data(ebus_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_sel(rsp_sel), .rsp_last(rsp_last), .rsp_err(rsp_err), .rsp_par(rsp_par)
  );

  function automatic logic exp_par(input logic [0:35] d);
`ifdef EBUS_DIAG_PARITY_EN
    return (($countones(d) % 2) == 0) ? 1'b1 : 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic fill_tbl();
    for (int i = 0; i < 8; i++) tbl[i] = {$urandom(), $urandom()} & 36'hF_FFFF_FFFF;
  endtask

  // Present one request for one cycle; returns at the negedge after the accept edge
  task automatic send_req(input int sel, input logic scan);
    @(negedge clk);
    req_valid = 1'b1;
    req_sel   = 3'(sel);
    req_scan  = scan;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Count negedges until rsp_valid; bounded so a dead DUT shows as a bad latency
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (rsp_valid !== 1'b1 && cyc < TMO + 8) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b0; req_sel = 3'd0; req_scan = 1'b0;
    rsp_ready = 1'b0; drv_en = 1'b1;
    fill_tbl();
    repeat (2) @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (diag_read_12x !== 1'b0 || diag_sel !== 3'd0) begin errors++; $display("FAIL reset_diag got %b/%0d want 0/0", diag_read_12x, diag_sel); end
    checks++; if (rsp_data !== 36'd0 || rsp_last !== 1'b0 || rsp_err !== 1'b0 || rsp_par !== 1'b0 || rsp_sel !== 3'd0) begin
      errors++; $display("FAIL reset_rsp_fields got data=%o last=%b err=%b par=%b sel=%0d want all 0", rsp_data, rsp_last, rsp_err, rsp_par, rsp_sel);
    end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1 || diag_read_12x !== 1'b0) begin errors++; $display("FAIL idle_after_reset got ready=%b diag=%b want 1/0", req_ready, diag_read_12x); end
  endtask

  task automatic test_single();
    int cyc;
    tbl[0] = 36'o123456701234;
    send_req(0, 1'b0);
    checks++; if (diag_read_12x !== 1'b1 || diag_sel !== 3'd0 || req_ready !== 1'b0) begin
      errors++; $display("FAIL single_issue got diag=%b sel=%0d ready=%b want 1/0/0", diag_read_12x, diag_sel, req_ready);
    end
    wait_valid(cyc);
    checks++; if (cyc !== SETTLE + 1) begin errors++; $display("FAIL single_latency got %0d want %0d", cyc, SETTLE + 1); end
    checks++; if (rsp_data !== 36'o123456701234) begin errors++; $display("FAIL single_data got %o want %o", rsp_data, 36'o123456701234); end
    checks++; if (rsp_sel !== 3'd0 || rsp_last !== 1'b1 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL single_flags got sel=%0d last=%b err=%b want 0/1/0", rsp_sel, rsp_last, rsp_err);
    end
    checks++; if (rsp_par !== exp_par(36'o123456701234)) begin errors++; $display("FAIL single_par got %b want %b", rsp_par, exp_par(36'o123456701234)); end
    checks++; if (diag_read_12x !== 1'b0) begin errors++; $display("FAIL single_bus_release got %b want 0", diag_read_12x); end
    handshake();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL single_done got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
  endtask

  task automatic test_scan();
    int cyc;
    fill_tbl();
    send_req(5, 1'b1);
    for (int s = 5; s <= 7; s++) begin
      wait_valid(cyc);
      checks++; if (cyc !== SETTLE + 1) begin errors++; $display("FAIL scan_latency sel=%0d got %0d want %0d", s, cyc, SETTLE + 1); end
      checks++; if (rsp_data !== tbl[s] || rsp_sel !== 3'(s)) begin
        errors++; $display("FAIL scan_word got data=%o sel=%0d want %o/%0d", rsp_data, rsp_sel, tbl[s], s);
      end
      checks++; if (rsp_last !== (s == 7) || rsp_err !== 1'b0) begin
        errors++; $display("FAIL scan_last sel=%0d got last=%b err=%b want %b/0", s, rsp_last, rsp_err, (s == 7));
      end
      checks++; if (diag_read_12x !== 1'b0) begin errors++; $display("FAIL scan_gap sel=%0d got diag=%b want 0", s, diag_read_12x); end
      handshake();
      if (s < 7) begin
        checks++; if (diag_read_12x !== 1'b1 || diag_sel !== 3'(s + 1) || rsp_valid !== 1'b0) begin
          errors++; $display("FAIL scan_next got diag=%b sel=%0d valid=%b want 1/%0d/0", diag_read_12x, diag_sel, rsp_valid, s + 1);
        end
      end else begin
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL scan_end got ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    int sel;
    fill_tbl();
    sel = $urandom_range(0, 7);
    send_req(sel, 1'b0);
    wait_valid(cyc);
    checks++; if (cyc !== SETTLE + 1) begin errors++; $display("FAIL bp_latency got %0d want %0d", cyc, SETTLE + 1); end
    req_valid = 1'b1;
    req_sel   = 3'($urandom_range(0, 7));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== tbl[sel] || rsp_sel !== 3'(sel) || rsp_last !== 1'b1 ||
                    diag_read_12x !== 1'b0 || req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc=%0d got valid=%b data=%o sel=%0d last=%b diag=%b ready=%b want 1/%o/%0d/1/0/0",
                           i, rsp_valid, rsp_data, rsp_sel, rsp_last, diag_read_12x, req_ready, tbl[sel], sel);
      end
    end
    req_valid = 1'b0;
    handshake();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", rsp_valid, req_ready); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || diag_read_12x !== 1'b0) begin errors++; $display("FAIL bp_single got valid=%b diag=%b want 0/0", rsp_valid, diag_read_12x); end
  endtask

  task automatic test_timeout();
    int cyc;
    drv_en = 1'b0;
    send_req(2, 1'b1);
    wait_valid(cyc);
    checks++; if (cyc !== TMO) begin errors++; $display("FAIL to_latency got %0d want %0d", cyc, TMO); end
    checks++; if (rsp_err !== 1'b1 || rsp_data !== 36'd0 || rsp_last !== 1'b1 || rsp_sel !== 3'd2) begin
      errors++; $display("FAIL to_word got err=%b data=%o last=%b sel=%0d want 1/0/1/2", rsp_err, rsp_data, rsp_last, rsp_sel);
    end
    checks++; if (rsp_par !== exp_par(36'd0)) begin errors++; $display("FAIL to_par got %b want %b", rsp_par, exp_par(36'd0)); end
    handshake();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL to_end got ready=%b valid=%b want 1/0", req_ready, rsp_valid); end
    drv_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    int sel;
    fill_tbl();
    sel = $urandom_range(0, 7);
    send_req(sel, 1'b1);
    @(negedge clk);
    checks++; if (diag_read_12x !== 1'b1) begin errors++; $display("FAIL rst_mid_active got %b want 1", diag_read_12x); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++; if (diag_read_12x !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid got diag=%b valid=%b ready=%b want 0/0/1", diag_read_12x, rsp_valid, req_ready);
    end
    reset_n = 1'b1;
    send_req(sel, 1'b0);
    wait_valid(cyc);
    checks++; if (cyc !== SETTLE + 1 || rsp_data !== tbl[sel] || rsp_sel !== 3'(sel) || rsp_last !== 1'b1) begin
      errors++; $display("FAIL rst_mid_recover got lat=%0d data=%o sel=%0d last=%b want %0d/%o/%0d/1", cyc, rsp_data, rsp_sel, rsp_last, SETTLE + 1, tbl[sel], sel);
    end
    handshake();
  endtask

  task automatic test_parity();
    int cyc;
    tbl[3] = 36'o000000000001;
    send_req(3, 1'b0);
    wait_valid(cyc);
    checks++; if (rsp_data !== 36'o000000000001 || rsp_par !== 1'b0) begin
      errors++; $display("FAIL par_one got data=%o par=%b want 1/0", rsp_data, rsp_par);
    end
    handshake();
    tbl[4] = 36'o000000000003;
    send_req(4, 1'b0);
    wait_valid(cyc);
    checks++; if (rsp_par !== exp_par(36'o000000000003)) begin errors++; $display("FAIL par_two got %b want %b", rsp_par, exp_par(36'o000000000003)); end
    handshake();
  endtask

  task automatic test_random();
    int cyc, sel, nwords, exp_lat;
    logic scan, drv;
    logic [0:35] exp_data;
    for (int it = 0; it < 25; it++) begin
      fill_tbl();
      sel    = $urandom_range(0, 7);
      scan   = 1'($urandom_range(0, 1));
      drv    = ($urandom_range(0, 4) != 0);
      drv_en = drv;
      nwords  = !drv ? 1 : (scan ? 8 - sel : 1);
      exp_lat = drv ? SETTLE + 1 : TMO;
      send_req(sel, scan);
      for (int k = 0; k < nwords; k++) begin
        exp_data = drv ? tbl[sel + k] : 36'd0;
        wait_valid(cyc);
        checks++; if (cyc !== exp_lat || rsp_data !== exp_data || rsp_sel !== 3'(sel + k) ||
                      rsp_last !== (k == nwords - 1) || rsp_err !== !drv || rsp_par !== exp_par(exp_data)) begin
          errors++; $display("FAIL rand it=%0d k=%0d got lat=%0d data=%o sel=%0d last=%b err=%b par=%b want %0d/%o/%0d/%b/%b/%b",
                             it, k, cyc, rsp_data, rsp_sel, rsp_last, rsp_err, rsp_par,
                             exp_lat, exp_data, sel + k, (k == nwords - 1), !drv, exp_par(exp_data));
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        handshake();
      end
      checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rand_end it=%0d got ready=%b valid=%b want 1/0", it, req_ready, rsp_valid); end
    end
    drv_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_scan();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_parity();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
